// File: rtl/hazard_ctrl_unit.sv
// Decode-stage hazard controller: RAW detection against in-flight writers, a
// control-hazard sequencer for branch/call/ret with watchdog, and a stall counter.
module hazard_ctrl_unit #(
    parameter int NUM_STAGES  = 3,
    parameter int NUM_RD      = 2,
    parameter int REG_W       = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int WDOG_MAX    = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*REG_W-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_STAGES*REG_W-1:0] wr_addr,
    input  logic [NUM_STAGES-1:0]       wr_en,
    input  logic                        branch,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        pc_update,
    input  logic                        stall_clr,
    output logic                        data_hazard,
    output logic                        pc_hazard,
    output logic [NUM_STAGES-1:0]       hazard_mask,
    output logic                        busy,
    output logic                        pc_timeout,
    output logic [STALL_CNT_W-1:0]      stall_cnt,
    output logic [1:0]                  dbg_state
);

    localparam int WDOG_W = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CALL_WAIT = 2'd1,
        S_PC_WAIT   = 2'd2,
        S_PC_DRAIN  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WDOG_W-1:0]       r_wdog;
    logic                    r_pc_timeout;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic [NUM_STAGES-1:0]   w_mask;
    logic                    w_raw;
    logic                    w_dh;
    logic                    w_ph;
    logic                    w_wdog_abort;

    // Register 0 is hard-wired to zero, so reading it never depends on a writer.
    always_comb begin
        w_mask = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r] && wr_en[s] &&
                    (rd_addr[r*REG_W +: REG_W] == wr_addr[s*REG_W +: REG_W]) &&
                    !((ZERO_REG_EN != 0) && (rd_addr[r*REG_W +: REG_W] == '0))) begin
                    w_mask[s] = 1'b1;
                end
            end
        end
    end

    assign w_raw = |w_mask;

    always_comb begin
        w_next       = r_state;
        w_dh         = 1'b0;
        w_ph         = 1'b0;
        w_wdog_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dh = w_raw & ~branch;
                w_ph = branch | ((call | ret) & ~w_raw);
                if (branch)
                    w_next = S_PC_WAIT;
                else if ((call | ret) && w_raw)
                    w_next = S_CALL_WAIT;
                else if (call | ret)
                    w_next = S_PC_WAIT;
            end
            S_CALL_WAIT: begin
                w_dh = w_raw;
                w_ph = ~w_raw;
                if (!w_raw)
                    w_next = S_PC_WAIT;
            end
            S_PC_WAIT: begin
                w_ph = 1'b1;
                // A target resolved on the final watchdog cycle still counts.
                if (pc_update) begin
                    w_next = S_PC_DRAIN;
                end else if (r_wdog == WDOG_W'(WDOG_MAX - 1)) begin
                    w_next       = S_IDLE;
                    w_wdog_abort = 1'b1;
                end
            end
            S_PC_DRAIN: begin
                w_dh   = w_raw;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wdog       <= '0;
            r_pc_timeout <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pc_timeout <= w_wdog_abort;
            if (r_state == S_PC_WAIT && w_next == S_PC_WAIT)
                r_wdog <= r_wdog + 1'b1;
            else
                r_wdog <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stall_clr)
            r_stall_cnt <= '0;
        else if ((data_hazard || pc_hazard) && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign data_hazard = ~rst & w_dh;
    assign pc_hazard   = ~rst & w_ph;
    assign hazard_mask = rst ? '0 : w_mask;
    assign busy        = (r_state != S_IDLE);
    assign pc_timeout  = r_pc_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign dbg_state   = r_state;

endmodule
